// File: rtl/seg7_multi_display.sv
`default_nettype none
// ============================================================================
// Module   : seg7_multi_display
// Brief    : Multi-digit active-low 7-segment driver, hex or double-dabble
//            decimal, with leading-zero blanking, DP, blink and overflow.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_multi_display #(
    parameter int P_DIGITS    = 6,
    parameter int P_DATA_W    = 24,
    parameter int P_BLINK_DIV = 25000000
) (
    input  logic                    CLK1,
    input  logic                    RST,
    input  logic [P_DATA_W-1:0]     DATA_IN,
    input  logic                    LOAD,
    input  logic                    MODE,
    input  logic                    BLANK_LZ,
    input  logic [P_DIGITS-1:0]     DP_IN,
    input  logic [P_DIGITS-1:0]     BLINK_EN,
    output logic                    BUSY,
    output logic                    OVF,
    output logic [8*P_DIGITS-1:0]   HEX_OUT
);

    // Every 3 binary bits need less than one decimal digit, so this bounds the BCD width.
    localparam int c_BCD_DIGITS = (P_DATA_W + 2) / 3;
    localparam int c_BCD_W      = 4 * c_BCD_DIGITS;
    localparam int c_DISP_W     = 4 * P_DIGITS;
    localparam int c_DATA_EXT_W = (c_DISP_W > P_DATA_W) ? c_DISP_W : P_DATA_W;
    localparam int c_BCD_EXT_W  = (c_DISP_W > c_BCD_W)  ? c_DISP_W : c_BCD_W;
    localparam int c_CNT_W      = (P_DATA_W > 1) ? $clog2(P_DATA_W) : 1;
    localparam int c_BLINK_W    = $clog2(P_BLINK_DIV);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CONV = 1'b1;

    logic [0:0]              r_state;
    logic [c_DISP_W-1:0]     r_digits;
    logic [P_DATA_W-1:0]     r_bin;
    logic [c_BCD_W-1:0]      r_bcd;
    logic [c_CNT_W-1:0]      r_bit;
    logic [c_BLINK_W-1:0]    r_blink_cnt;
    logic                    r_phase_on;

    logic [c_DATA_EXT_W-1:0] w_data_ext;
    logic [c_DISP_W-1:0]     w_hex_digits;
    logic                    w_hex_ovf;
    logic [c_BCD_W-1:0]      w_bcd_adj;
    logic [c_BCD_W-1:0]      w_next_bcd;
    logic [c_BCD_EXT_W-1:0]  w_bcd_ext;
    logic [c_DISP_W-1:0]     w_bcd_digits;
    logic                    w_bcd_ovf;
    logic [P_DIGITS-1:0]     w_zero_above;
    logic [8*P_DIGITS-1:0]   w_hex_next;

    function automatic logic [7:0] f_seg7(input logic [3:0] i_nib);
        logic [7:0] v_seg;
        unique case (i_nib)
            4'h0: v_seg = 8'hC0;  4'h1: v_seg = 8'hF9;
            4'h2: v_seg = 8'hA4;  4'h3: v_seg = 8'hB0;
            4'h4: v_seg = 8'h99;  4'h5: v_seg = 8'h92;
            4'h6: v_seg = 8'h82;  4'h7: v_seg = 8'hF8;
            4'h8: v_seg = 8'h80;  4'h9: v_seg = 8'h98;
            4'hA: v_seg = 8'h88;  4'hB: v_seg = 8'h83;
            4'hC: v_seg = 8'hA7;  4'hD: v_seg = 8'hA1;
            4'hE: v_seg = 8'h86;  default: v_seg = 8'h8E;
        endcase
        return v_seg;
    endfunction

    assign w_data_ext   = c_DATA_EXT_W'(DATA_IN);
    assign w_hex_digits = w_data_ext[c_DISP_W-1:0];
    assign w_hex_ovf    = |(w_data_ext >> c_DISP_W);

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int j = 0; j < c_BCD_DIGITS; j++) begin
            if (r_bcd[4*j +: 4] >= 4'd5) begin
                w_bcd_adj[4*j +: 4] = r_bcd[4*j +: 4] + 4'd3;
            end
        end
    end

    assign w_next_bcd   = (w_bcd_adj << 1) | c_BCD_W'(r_bin[P_DATA_W-1]);
    assign w_bcd_ext    = c_BCD_EXT_W'(w_next_bcd);
    assign w_bcd_digits = w_bcd_ext[c_DISP_W-1:0];
    assign w_bcd_ovf    = |(w_bcd_ext >> c_DISP_W);

    always_ff @(posedge CLK1) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_digits <= '0;
            r_bin    <= '0;
            r_bcd    <= '0;
            r_bit    <= '0;
            BUSY     <= 1'b0;
            OVF      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (LOAD) begin
                        if (MODE) begin
                            r_bin   <= DATA_IN;
                            r_bcd   <= '0;
                            r_bit   <= '0;
                            BUSY    <= 1'b1;
                            r_state <= S_CONV;
                        end else begin
                            r_digits <= w_hex_digits;
                            OVF      <= w_hex_ovf;
                        end
                    end
                end
                S_CONV: begin
                    r_bcd <= w_next_bcd;
                    r_bin <= r_bin << 1;
                    r_bit <= r_bit + 1'b1;
                    if (r_bit == c_CNT_W'(P_DATA_W - 1)) begin
                        r_digits <= w_bcd_digits;
                        OVF      <= w_bcd_ovf;
                        BUSY     <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // w_zero_above[i]: digit i and every digit above it are zero.
    always_comb begin
        logic v_acc;
        v_acc        = 1'b1;
        w_zero_above = '0;
        for (int i = P_DIGITS - 1; i >= 0; i--) begin
            v_acc           = v_acc && (r_digits[4*i +: 4] == 4'd0);
            w_zero_above[i] = v_acc;
        end
    end

    always_comb begin
        logic [7:0] v_seg;
        w_hex_next = '0;
        for (int i = 0; i < P_DIGITS; i++) begin
            v_seg = OVF ? 8'hBF : f_seg7(r_digits[4*i +: 4]);
            if (BLANK_LZ && !OVF && (i != 0) && w_zero_above[i]) begin
                v_seg = 8'hFF;
            end else if (DP_IN[i]) begin
                v_seg[7] = 1'b0;
            end
            if (!r_phase_on && BLINK_EN[i]) begin
                v_seg = 8'hFF;
            end
            w_hex_next[8*i +: 8] = v_seg;
        end
    end

    always_ff @(posedge CLK1) begin
        if (RST) begin
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
            HEX_OUT     <= {P_DIGITS{8'hC0}};
        end else begin
            if (r_blink_cnt == c_BLINK_W'(P_BLINK_DIV - 1)) begin
                r_blink_cnt <= '0;
                r_phase_on  <= ~r_phase_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
            HEX_OUT <= w_hex_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_multi_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_multi_display
// Brief    : Self-checking bench for seg7_multi_display (4 digits, 16-bit data).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_multi_display;

    logic        CLK1 = 1'b0;
    logic        RST;
    logic [15:0] DATA_IN;
    logic        LOAD;
    logic        MODE;
    logic        BLANK_LZ;
    logic [3:0]  DP_IN;
    logic [3:0]  BLINK_EN;
    logic        BUSY;
    logic        OVF;
    logic [31:0] HEX_OUT;

    seg7_multi_display #(
        .P_DIGITS    (4),
        .P_DATA_W    (16),
        .P_BLINK_DIV (4)
    ) dut (
        .CLK1     (CLK1),
        .RST      (RST),
        .DATA_IN  (DATA_IN),
        .LOAD     (LOAD),
        .MODE     (MODE),
        .BLANK_LZ (BLANK_LZ),
        .DP_IN    (DP_IN),
        .BLINK_EN (BLINK_EN),
        .BUSY     (BUSY),
        .OVF      (OVF),
        .HEX_OUT  (HEX_OUT)
    );

    always #5 CLK1 = ~CLK1;

    typedef struct {
        logic [31:0] hex;
        logic        ovf;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  c_seg [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h98, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E};

    task automatic tick();
        @(posedge CLK1);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] hex, input logic ovf);
        exp_t e;
        e.hex = hex;
        e.ovf = ovf;
        q.push_back(e);
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = q.pop_front();
            check({tag, "_hex"}, HEX_OUT, e.hex);
            check({tag, "_ovf"}, {31'd0, OVF}, {31'd0, e.ovf});
        end
    endtask

    task automatic load(input logic [15:0] v, input logic m);
        DATA_IN = v;
        MODE    = m;
        LOAD    = 1'b1;
        tick();
        LOAD    = 1'b0;
    endtask

    task automatic hex_load(input logic [15:0] v);
        load(v, 1'b0);
        tick();
    endtask

    // Returns the number of sampled cycles with BUSY high; LOAD=1 injected at cycle 5.
    task automatic dec_load(input logic [15:0] v, input logic inject, output int cycles);
        load(v, 1'b1);
        cycles = 0;
        while (BUSY === 1'b1 && cycles < 100) begin
            if (inject && cycles == 5) begin
                DATA_IN = 16'd1;
                MODE    = 1'b0;
                LOAD    = 1'b1;
            end
            tick();
            LOAD = 1'b0;
            cycles++;
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        logic [7:0] s[17];
        int         k;

        RST = 1'b1; DATA_IN = '0; LOAD = 1'b0; MODE = 1'b0;
        BLANK_LZ = 1'b0; DP_IN = '0; BLINK_EN = '0;

        // Reset
        repeat (10) tick();
        RST = 1'b0;
        push(32'hC0C0C0C0, 1'b0);
        tick();
        check_pop("reset");
        check("reset_busy", {31'd0, BUSY}, 32'd0);

        // Hex load and full nibble sweep on digit 0
        push(32'hF988B08E, 1'b0);
        hex_load(16'h1A3F);
        check_pop("hex_1A3F");
        for (int n = 0; n < 16; n++) begin
            push({24'hF988B0, c_seg[n]}, 1'b0);
            hex_load({12'h1A3, 4'(n)});
            check_pop($sformatf("sweep_%0d", n));
        end

        // Decimal 9876 with an ignored mid-conversion LOAD
        load(16'd9876, 1'b1);
        check("dec_busy_start", {31'd0, BUSY}, 32'd1);
        cyc = 1;
        while (BUSY === 1'b1 && cyc < 100) begin
            if (cyc == 5) begin
                DATA_IN = 16'd1; MODE = 1'b0; LOAD = 1'b1;
            end
            tick();
            LOAD = 1'b0;
            if (cyc == 8) check("dec_hold", HEX_OUT, 32'hF988B08E);
            if (BUSY === 1'b1) cyc++;
            else break;
        end
        check("dec_busy_len", cyc, 32'd16);
        push(32'h9880F882, 1'b0);
        tick();
        check_pop("dec_9876");

        // Decimal overflow, then hex clears it
        push(32'hBFBFBFBF, 1'b1);
        dec_load(16'd10000, 1'b0, cyc);
        check("ovf_busy_len", cyc, 32'd16);
        check_pop("dec_10000");
        push(32'hC0C0C0C0, 1'b0);
        hex_load(16'h0000);
        check_pop("hex_clear");

        // Hex overflow: bit above 4 digits cannot occur for 16-bit data, so check 16'hFFFF wraps cleanly
        push(32'h8E8E8E8E, 1'b0);
        hex_load(16'hFFFF);
        check_pop("hex_FFFF");

        // Leading-zero blanking
        BLANK_LZ = 1'b1;
        push(32'hFFFF99A4, 1'b0);
        dec_load(16'd42, 1'b0, cyc);
        check_pop("lz_42");
        push(32'hFFFFFFC0, 1'b0);
        dec_load(16'd0, 1'b0, cyc);
        check_pop("lz_0");
        push(32'hFFF9C0C0, 1'b0);
        hex_load(16'h0100);
        check_pop("lz_0100");
        BLANK_LZ = 1'b0;

        // Reset aborts a decimal conversion
        push(32'hF9A4B099, 1'b0);
        hex_load(16'h1234);
        check_pop("pre_abort");
        load(16'd9876, 1'b1);
        tick(); tick();
        check("abort_busy_before", {31'd0, BUSY}, 32'd1);
        RST = 1'b1;
        tick();
        check("abort_busy", {31'd0, BUSY}, 32'd0);
        check("abort_hex", HEX_OUT, 32'hC0C0C0C0);
        RST = 1'b0;
        push(32'hC0C0C0C0, 1'b0);
        tick(); tick();
        check_pop("abort_after");

        // Decimal point and blink on digit 0
        DP_IN = 4'b0001;
        BLINK_EN = 4'b0001;
        hex_load(16'h0000);
        for (int j = 0; j < 17; j++) begin
            tick();
            s[j] = HEX_OUT[7:0];
            check($sformatf("blink_upper_%0d", j), {8'd0, HEX_OUT[31:8]}, 32'h00C0C0C0);
        end
        k = 0;
        for (int j = 1; j <= 4; j++) begin
            if (k == 0 && s[j] != s[j-1]) k = j;
        end
        if (k == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL blink_toggle observed=%h expected=toggle", s[0]);
        end else begin
            check("blink_xor", {24'd0, s[k] ^ s[k-1]}, 32'h000000BF);
            check("blink_and", {24'd0, s[k] & s[k-1]}, 32'h00000040);
            for (int j = k; j < k + 12; j++) begin
                check($sformatf("blink_seq_%0d", j), {24'd0, s[j]},
                      {24'd0, (((j - k) / 4) % 2 == 0) ? s[k] : s[k-1]});
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
